// File: rtl/adder_pkg.sv
// Shared definitions between the signed adder stage and its accumulator consumer.
package adder_pkg;

  localparam int N_BITS = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// Signed saturating add: ACC_BITS accumulator plus a sign-extended N_BITS sample.
module sat_add #(
  parameter int ACC_BITS = 16,
  parameter int N_BITS   = 8
) (
  input  logic [ACC_BITS-1:0] acc,
  input  logic [N_BITS-1:0]   sample,
  output logic [ACC_BITS-1:0] result,
  output logic                sat
);

  logic [ACC_BITS:0] wide;

  always_comb begin
    wide = {acc[ACC_BITS-1], acc} + {{(ACC_BITS + 1 - N_BITS){sample[N_BITS-1]}}, sample};
    // With one guard bit, a differing top pair means the true sum left the ACC_BITS range.
    sat  = wide[ACC_BITS] ^ wide[ACC_BITS-1];
    if (sat) begin
      result = wide[ACC_BITS] ? {1'b1, {(ACC_BITS - 1){1'b0}}}
                              : {1'b0, {(ACC_BITS - 1){1'b1}}};
    end else begin
      result = wide[ACC_BITS-1:0];
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// Frames FRAME_LEN adder results into a saturated total plus flag counts,
// handing each frame result downstream over a valid/ready port.
module sum_accumulator
  import adder_pkg::*;
#(
  parameter int   N_BITS    = adder_pkg::N_BITS,
  parameter int   ACC_BITS  = 16,
  parameter int   FRAME_LEN = 4,
  localparam int  CNT_BITS  = $clog2(FRAME_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_BITS-1:0]   sum,
  input  logic                is_negative,
  input  logic                is_zero,
  input  logic                is_even,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_BITS-1:0] total,
  output logic [CNT_BITS-1:0] neg_count,
  output logic [CNT_BITS-1:0] zero_count,
  output logic [CNT_BITS-1:0] even_count,
  output logic                overflow
);

  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(FRAME_LEN - 1);

  acc_state_t          state;
  logic [CNT_BITS-1:0] idx;
  logic [ACC_BITS-1:0] next_total;
  logic                next_sat;

  sat_add #(
    .ACC_BITS (ACC_BITS),
    .N_BITS   (N_BITS)
  ) u_sat_add (
    .acc    (total),
    .sample (sum),
    .result (next_total),
    .sat    (next_sat)
  );

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      idx        <= '0;
      total      <= '0;
      neg_count  <= '0;
      zero_count <= '0;
      even_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            total      <= next_total;
            overflow   <= overflow | next_sat;
            neg_count  <= neg_count + CNT_BITS'(is_negative);
            zero_count <= zero_count + CNT_BITS'(is_zero);
            even_count <= even_count + CNT_BITS'(is_even);
            idx        <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state      <= ACCUM;
            idx        <= '0;
            total      <= '0;
            neg_count  <= '0;
            zero_count <= '0;
            even_count <= '0;
            overflow   <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
